mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 161 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer: turns an EX/MEM request into one data-memory access,
// handles lane steering/extension, and reports misaligned, illegal or timed-out accesses.
module mem_access_unit #(
   parameter logic [7:0] TIMEOUT = 8'd255
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] MEM_ALU_RESULT,
   input  logic [31:0] MEM_READ_DATA2,
   input  logic        MEM_MEM_READ,
   input  logic        MEM_MEM_WRITE,
   input  logic [2:0]  MEM_FUNC3,
   output logic [31:0] DM_ADDR,
   output logic [31:0] DM_WDATA,
   output logic [3:0]  DM_BYTE_EN,
   output logic        DM_READ,
   output logic        DM_WRITE,
   input  logic [31:0] DM_RDATA,
   input  logic        DM_READY,
   output logic [31:0] LOAD_DATA,
   output logic        MEM_BUSY,
   output logic        MEM_FAULT
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   state_t      r_state, w_next;
   logic [7:0]  r_cnt;
   logic [2:0]  r_func3;
   logic [1:0]  r_off;
   logic        r_is_load;

   logic        w_req, w_legal, w_misal, w_ok, w_bad;
   logic        w_start, w_complete, w_tmo;
   logic [1:0]  w_off;
   logic [3:0]  w_be;
   logic [31:0] w_wdata, w_load_val;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Write takes priority; a simultaneous read is simply dropped.
   assign w_req = MEM_MEM_WRITE | MEM_MEM_READ;
   assign w_off = MEM_ALU_RESULT[1:0];

   always_comb begin
      w_legal = 1'b0;
      w_misal = 1'b0;
      if (MEM_MEM_WRITE)
         w_legal = (MEM_FUNC3 == 3'b000) || (MEM_FUNC3 == 3'b001) || (MEM_FUNC3 == 3'b010);
      else
         w_legal = (MEM_FUNC3 == 3'b000) || (MEM_FUNC3 == 3'b001) || (MEM_FUNC3 == 3'b010) ||
                   (MEM_FUNC3 == 3'b100) || (MEM_FUNC3 == 3'b101);
      if (MEM_FUNC3[1:0] == 2'b10)
         w_misal = (w_off != 2'b00);
      else if (MEM_FUNC3[1:0] == 2'b01)
         w_misal = w_off[0];
   end

   assign w_ok  = w_req & w_legal & ~w_misal;
   assign w_bad = w_req & ~w_ok;

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = MEM_READ_DATA2;
      case (MEM_FUNC3[1:0])
         2'b00: begin
            w_be    = 4'b0001 << w_off;
            w_wdata = {4{MEM_READ_DATA2[7:0]}};
         end
         2'b01: begin
            w_be    = w_off[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{MEM_READ_DATA2[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      w_byte = DM_RDATA[{r_off, 3'b000} +: 8];
      w_half = r_off[1] ? DM_RDATA[31:16] : DM_RDATA[15:0];
      case (r_func3)
         3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
         3'b100:  w_load_val = {24'd0, w_byte};
         3'b101:  w_load_val = {16'd0, w_half};
         default: w_load_val = DM_RDATA;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_start    = 1'b0;
      w_complete = 1'b0;
      w_tmo      = 1'b0;
      MEM_BUSY   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_ok) begin
               w_start  = 1'b1;
               MEM_BUSY = 1'b1;
               w_next   = S_ACCESS;
            end
         end
         S_ACCESS: begin
            MEM_BUSY = 1'b1;
            if (DM_READY) begin
               w_complete = 1'b1;
               w_next     = S_DONE;
            end else if (r_cnt == TIMEOUT - 8'd1) begin
               w_tmo  = 1'b1;
               w_next = S_DONE;
            end
         end
         // The finished instruction is still in EX/MEM here, so its request is ignored.
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         DM_ADDR    <= '0;
         DM_WDATA   <= '0;
         DM_BYTE_EN <= '0;
         DM_READ    <= 1'b0;
         DM_WRITE   <= 1'b0;
         LOAD_DATA  <= '0;
         MEM_FAULT  <= 1'b0;
         r_cnt      <= '0;
         r_func3    <= '0;
         r_off      <= '0;
         r_is_load  <= 1'b0;
      end else begin
         MEM_FAULT <= ((r_state == S_IDLE) && w_bad) || w_tmo;
         if (w_start) begin
            DM_ADDR    <= {MEM_ALU_RESULT[31:2], 2'b00};
            DM_WDATA   <= MEM_MEM_WRITE ? w_wdata : 32'd0;
            DM_BYTE_EN <= MEM_MEM_WRITE ? w_be : 4'b0000;
            DM_WRITE   <= MEM_MEM_WRITE;
            DM_READ    <= ~MEM_MEM_WRITE;
            r_cnt      <= '0;
            r_func3    <= MEM_FUNC3;
            r_off      <= w_off;
            r_is_load  <= ~MEM_MEM_WRITE;
         end else if (w_complete || w_tmo) begin
            DM_READ  <= 1'b0;
            DM_WRITE <= 1'b0;
            if (w_complete && r_is_load)
               LOAD_DATA <= w_load_val;
         end else if (r_state == S_ACCESS) begin
            r_cnt <= r_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed corner cases then random
// transactions, all compared against a transaction-level model of the access rules.
module tb_mem_access_unit;

   localparam logic [7:0] TO = 8'd4;

   logic        CLK = 1'b0;
   logic        RST;
   logic [31:0] MEM_ALU_RESULT, MEM_READ_DATA2, DM_RDATA;
   logic        MEM_MEM_READ, MEM_MEM_WRITE, DM_READY;
   logic [2:0]  MEM_FUNC3;
   logic [31:0] DM_ADDR, DM_WDATA, LOAD_DATA;
   logic [3:0]  DM_BYTE_EN;
   logic        DM_READ, DM_WRITE, MEM_BUSY, MEM_FAULT;

   int n_chk = 0;
   int n_err = 0;
   logic [31:0] exp_load = 32'd0;

   mem_access_unit #(.TIMEOUT(TO)) dut (
      .CLK(CLK), .RST(RST),
      .MEM_ALU_RESULT(MEM_ALU_RESULT), .MEM_READ_DATA2(MEM_READ_DATA2),
      .MEM_MEM_READ(MEM_MEM_READ), .MEM_MEM_WRITE(MEM_MEM_WRITE), .MEM_FUNC3(MEM_FUNC3),
      .DM_ADDR(DM_ADDR), .DM_WDATA(DM_WDATA), .DM_BYTE_EN(DM_BYTE_EN),
      .DM_READ(DM_READ), .DM_WRITE(DM_WRITE), .DM_RDATA(DM_RDATA), .DM_READY(DM_READY),
      .LOAD_DATA(LOAD_DATA), .MEM_BUSY(MEM_BUSY), .MEM_FAULT(MEM_FAULT)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rd);
      int unsigned b, h, idx;
      idx = addr % 4;
      b = (rd >> (8 * idx)) & 32'hFF;
      h = (rd >> (16 * (idx / 2))) & 32'hFFFF;
      case (f3)
         3'd0:    return (b >= 128) ? (b | 32'hFFFFFF00) : b;
         3'd1:    return (h >= 32768) ? (h | 32'hFFFF0000) : h;
         3'd4:    return b;
         3'd5:    return h;
         default: return rd;
      endcase
   endfunction

   task automatic clr_req();
      MEM_MEM_READ  = 1'b0;
      MEM_MEM_WRITE = 1'b0;
      DM_READY      = 1'b0;
   endtask

   // One complete request from presentation in IDLE back to IDLE; dly = wait cycles before READY.
   task automatic txn(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] rdat, input int dly);
      bit req, legal, mis, ok, tmo, fin;
      int sz, idx, k;
      logic [31:0] e_wd;
      logic [3:0]  e_be;
      req = rd | wr;
      sz  = f3 % 4;
      idx = addr % 4;
      legal = wr ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
      mis   = (sz == 2 && idx != 0) || (sz == 1 && (idx % 2) == 1);
      ok    = req && legal && !mis;
      MEM_MEM_READ = rd; MEM_MEM_WRITE = wr; MEM_FUNC3 = f3;
      MEM_ALU_RESULT = addr; MEM_READ_DATA2 = wd; DM_RDATA = rdat; DM_READY = 1'b0;
      #1;
      chk("busy_idle", MEM_BUSY, ok);
      @(posedge CLK); #1;
      if (!ok) begin
         chk("fault_bad", MEM_FAULT, req);
         chk("no_read", DM_READ, 0);
         chk("no_write", DM_WRITE, 0);
         chk("busy_bad", MEM_BUSY, 0);
         chk("ld_hold_bad", LOAD_DATA, exp_load);
         clr_req();
         @(posedge CLK); #1;
         chk("fault_clr", MEM_FAULT, 0);
      end else begin
         if (sz == 0) begin e_be = 4'b0001 << idx; e_wd = (wd & 32'hFF) * 32'h01010101; end
         else if (sz == 1) begin e_be = 4'b0011 << (idx & 2); e_wd = (wd & 32'hFFFF) * 32'h00010001; end
         else begin e_be = 4'b1111; e_wd = wd; end
         if (!wr) e_be = 4'b0000;
         chk("addr", DM_ADDR, addr & ~32'd3);
         chk("byte_en", DM_BYTE_EN, e_be);
         if (wr) chk("wdata", DM_WDATA, e_wd);
         chk("fault_start", MEM_FAULT, 0);
         k = 0; fin = 0; tmo = 0;
         while (!fin) begin
            DM_READY = (k == dly);
            #1;
            chk("busy_acc", MEM_BUSY, 1);
            chk("rd_acc", DM_READ, !wr);
            chk("wr_acc", DM_WRITE, wr);
            chk("addr_stable", DM_ADDR, addr & ~32'd3);
            chk("be_stable", DM_BYTE_EN, e_be);
            @(posedge CLK); #1;
            if (k == dly) fin = 1;
            else if (k == TO - 1) begin fin = 1; tmo = 1; end
            k++;
         end
         if (tmo) chk("tmo_cycles", k, TO);
         if (!tmo && !wr) exp_load = ld_model(f3, addr, rdat);
         DM_READY = 1'b0;
         chk("rd_drop", DM_READ, 0);
         chk("wr_drop", DM_WRITE, 0);
         chk("fault_end", MEM_FAULT, tmo);
         chk("load_data", LOAD_DATA, exp_load);
         chk("busy_done", MEM_BUSY, 0);
         @(posedge CLK); #1;
         clr_req();
         #1;
         chk("fault_idle", MEM_FAULT, 0);
         chk("busy_back", MEM_BUSY, 0);
         chk("rd_idle", DM_READ, 0);
      end
   endtask

   initial begin
      RST = 1'b1;
      MEM_ALU_RESULT = '0; MEM_READ_DATA2 = '0; MEM_FUNC3 = '0; DM_RDATA = '0;
      clr_req();
      #3;
      chk("rst_addr", DM_ADDR, 0);
      chk("rst_wdata", DM_WDATA, 0);
      chk("rst_be", DM_BYTE_EN, 0);
      chk("rst_strobes", {DM_READ, DM_WRITE}, 0);
      chk("rst_load", LOAD_DATA, 0);
      chk("rst_fault", MEM_FAULT, 0);
      chk("rst_busy", MEM_BUSY, 0);
      #9 RST = 1'b0;
      #1;

      txn(1, 0, 3'b000, 32'h103, 32'h0, 32'h8000_0000, 0);
      chk("lb_neg", LOAD_DATA, 32'hFFFF_FF80);
      txn(0, 1, 3'b001, 32'h22, 32'h0000_BEEF, 32'h0, 2);
      txn(1, 0, 3'b010, 32'h41, 32'h0, 32'h1234_5678, 0);
      txn(1, 0, 3'b101, 32'h12, 32'h0, 32'hAAAA_5555, 10);
      chk("tmo_hold", LOAD_DATA, 32'hFFFF_FF80);
      txn(1, 1, 3'b010, 32'h8, 32'hCAFE_F00D, 32'h0, 1);

      // Reset arriving in the second ACCESS cycle of a load.
      MEM_MEM_READ = 1'b1; MEM_FUNC3 = 3'b010; MEM_ALU_RESULT = 32'h40;
      DM_RDATA = 32'h5A5A_5A5A; DM_READY = 1'b0;
      @(posedge CLK); #1;
      chk("rst_acc_rd", DM_READ, 1);
      @(posedge CLK); #1;
      RST = 1'b1;
      clr_req();
      #1;
      chk("rst_mid_rd", DM_READ, 0);
      chk("rst_mid_load", LOAD_DATA, 0);
      chk("rst_mid_busy", MEM_BUSY, 0);
      exp_load = 32'd0;
      #2 RST = 1'b0;
      @(posedge CLK); #1;
      chk("post_rst_rd", DM_READ, 0);
      txn(1, 0, 3'b001, 32'h2, 32'h0, 32'h8123_4567, 0);

      for (int i = 0; i < 200; i++) begin
         int sel;
         bit rd, wr;
         sel = $urandom_range(0, 7);
         rd = (sel >= 1 && sel <= 4) || sel == 7;
         wr = (sel >= 5);
         txn(rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, $urandom_range(0, 5));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
